// File: rtl/triumph_ex_arbiter.sv
// ---------------------------------------------------------------------------
// triumph_ex_arbiter
//
// Shares the single EX-stage ALU between two requesters. req0 is the main
// issue path and req1 is an auxiliary path. Only one operation is in flight
// at a time, and each operation walks through IDLE -> EXEC -> RESP.
//   IDLE : pick a winner, raise its ready, and drive the ALU inputs from it.
//   EXEC : the ALU has registered its inputs, so its result is captured here.
//   RESP : hold the captured result until the owner takes it.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin between req0/req1, 1 = req0 always wins
//   CNT_W      : width of each saturating per-requester grant counter
//
// Ports
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   reqN_valid_i / reqN_ready_o      request handshake (N = 0, 1)
//   reqN_op1_i, reqN_op2_i           32-bit operands
//   reqN_op_type_i                   7-bit ALU op code
//   rspN_valid_o / rspN_ready_i      response handshake towards the owner
//   rsp_data_o, rsp_zero_o           captured result and zero flag (shared)
//   alu_op1_o, alu_op2_o             ALU operand inputs
//   alu_op_type_o                    ALU op code input
//   alu_result_i, alu_zero_i         ALU result and zero flag
//   busy_o                           high whenever the FSM is not in IDLE
//   grant_cnt0_o, grant_cnt1_o       saturating accepted-request counters
//   rsp_err_o                        (TRIUMPH_EX_ARB_OPCHK_EN only) the
//                                    response belongs to an unsupported op
//
// Optional feature macro: TRIUMPH_EX_ARB_OPCHK_EN
// ---------------------------------------------------------------------------

`ifndef ALU_ADD
`define ALU_ADD 7'h01
`endif
`ifndef ALU_SUB
`define ALU_SUB 7'h02
`endif
`ifndef ALU_XOR
`define ALU_XOR 7'h03
`endif
`ifndef ALU_OR
`define ALU_OR  7'h04
`endif
`ifndef ALU_AND
`define ALU_AND 7'h05
`endif

module triumph_ex_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [31:0]      req0_op1_i,
    input  logic [31:0]      req0_op2_i,
    input  logic [6:0]       req0_op_type_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [31:0]      req1_op1_i,
    input  logic [31:0]      req1_op2_i,
    input  logic [6:0]       req1_op_type_i,
    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_zero_o,
    output logic [31:0]      alu_op1_o,
    output logic [31:0]      alu_op2_o,
    output logic [6:0]       alu_op_type_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_zero_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] grant_cnt0_o,
    output logic [CNT_W-1:0] grant_cnt1_o
`ifdef TRIUMPH_EX_ARB_OPCHK_EN
    ,
    output logic             rsp_err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q;
    logic        rr_q;
    logic        grant_any;
    logic        grant_sel;
    logic        accept;
    logic [31:0] sel_op1;
    logic [31:0] sel_op2;
    logic [6:0]  sel_op_type;
    logic        sel_op_ok;

    // Winner selection. A lone valid requester always wins; on a tie the
    // rr pointer decides unless fixed priority hands it straight to req0.
    always_comb begin
        grant_any = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_sel = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
        end else begin
            grant_sel = req1_valid_i;
        end
        sel_op1     = grant_sel ? req1_op1_i     : req0_op1_i;
        sel_op2     = grant_sel ? req1_op2_i     : req0_op2_i;
        sel_op_type = grant_sel ? req1_op_type_i : req0_op_type_i;
    end

`ifdef TRIUMPH_EX_ARB_OPCHK_EN
    // Unsupported op codes are still accepted, but the ALU sees zeros so no
    // garbage result can leak into the response.
    always_comb begin
        sel_op_ok = (sel_op_type == `ALU_ADD) || (sel_op_type == `ALU_SUB) ||
                    (sel_op_type == `ALU_XOR) || (sel_op_type == `ALU_OR)  ||
                    (sel_op_type == `ALU_AND);
    end
`else
    assign sel_op_ok = 1'b1;
`endif

    // Next-state and output decode. The ALU inputs are only non-zero in the
    // accept cycle, because the ALU registers them on that same edge.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        req0_ready_o  = 1'b0;
        req1_ready_o  = 1'b0;
        rsp0_valid_o  = 1'b0;
        rsp1_valid_o  = 1'b0;
        alu_op1_o     = '0;
        alu_op2_o     = '0;
        alu_op_type_o = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    accept       = 1'b1;
                    req0_ready_o = ~grant_sel;
                    req1_ready_o = grant_sel;
                    if (sel_op_ok) begin
                        alu_op1_o     = sel_op1;
                        alu_op2_o     = sel_op2;
                        alu_op_type_o = sel_op_type;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid_o = ~owner_q;
                rsp1_valid_o = owner_q;
                if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ownership, round-robin pointer and grant counters all update on accept.
    // The pointer always moves to the requester that just lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q      <= 1'b0;
            rr_q         <= 1'b0;
            grant_cnt0_o <= '0;
            grant_cnt1_o <= '0;
        end else if (accept) begin
            owner_q <= grant_sel;
            rr_q    <= ~grant_sel;
            if (!grant_sel && (grant_cnt0_o != {CNT_W{1'b1}})) begin
                grant_cnt0_o <= grant_cnt0_o + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (grant_sel && (grant_cnt1_o != {CNT_W{1'b1}})) begin
                grant_cnt1_o <= grant_cnt1_o + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef TRIUMPH_EX_ARB_OPCHK_EN
    // Remembers that the accepted op was unsupported, and raises the error
    // flag for its response; the flag clears on the next accept.
    logic op_bad_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_bad_q  <= 1'b0;
            rsp_err_o <= 1'b0;
        end else if (accept) begin
            op_bad_q  <= ~sel_op_ok;
            rsp_err_o <= 1'b0;
        end else if ((state_q == EXEC) && op_bad_q) begin
            rsp_err_o <= 1'b1;
        end
    end
`endif

    // Result capture in EXEC; the value then stays put through RESP and
    // beyond until the next operation overwrites it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_data_o <= '0;
            rsp_zero_o <= 1'b0;
        end else if (state_q == EXEC) begin
`ifdef TRIUMPH_EX_ARB_OPCHK_EN
            if (op_bad_q) begin
                rsp_data_o <= '0;
                rsp_zero_o <= 1'b1;
            end else begin
                rsp_data_o <= alu_result_i;
                rsp_zero_o <= alu_zero_i;
            end
`else
            rsp_data_o <= alu_result_i;
            rsp_zero_o <= alu_zero_i;
`endif
        end
    end

endmodule
